aes_dec_iter_ctrl: RTL and testbench
====================================

Name: aes_dec_iter_ctrl

Overview:
Iterative AES-128 decryption sequencer. It accepts one ciphertext/key pair over a valid/ready handshake and latches it. It then drives a single shared inverse-round datapath for 11 clock cycles, indexing round keys from the combinational KeyExpansion output, and returns the plaintext over a valid/ready handshake. It replaces the fully unrolled 10-round decryption chain where area matters more than throughput.

Parameters:
NR, 10, number of AES rounds; only 10 (AES-128) is supported, and other values are an elaboration error.
BLK_W, 128, block and key width in bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext/key pair is valid
in_ready  output  1  block can accept a new pair
in_ct  input  BLK_W  ciphertext
in_key  input  BLK_W  cipher key (round key 0)
out_valid  output  1  plaintext is valid
out_ready  input  1  consumer accepts the plaintext
out_pt  output  BLK_W  plaintext
busy  output  1  high while in PRE, ROUND or FINAL

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: FSM=IDLE, rnd=0, st=0, key_q=0, out_pt=0, out_valid=0, busy=0. in_ready is 1 after reset, because it is decoded from IDLE.
- Round-key numbering: rk[r], r=0..10, comes from KeyExpansion(key_q). rk[0] = key_q; rk[10] is the last encryption round key.
- FSM states: IDLE, PRE, ROUND, FINAL, DONE.
- IDLE: in_ready=1. On in_valid & in_ready: st<=in_ct, key_q<=in_key, then go to PRE.
- PRE (one cycle): st <= InvSubBytes(InvShiftRows(st ^ rk[10])). Set rnd<=1, then go to ROUND.
- ROUND (9 cycles, rnd=1..9): st <= InvSubBytes(InvShiftRows(InvMixColumns(st ^ rk[10-rnd]))). rnd increments. When rnd==9, go to FINAL instead.
- FINAL (one cycle): out_pt <= st ^ rk[0], out_valid<=1, then go to DONE.
- DONE: out_valid=1, and out_pt is held stable until out_ready.
  - out_ready=1: out_valid<=0 and go to IDLE.
  - out_ready=1 and in_valid=1 in the same cycle: the block accepts the new pair in that cycle and goes directly to PRE. in_ready = (FSM==IDLE) | (FSM==DONE & out_ready).
- Latency: the handshake edge is E0. out_valid is high after edge E11 (11 cycles). Back-to-back throughput is one block per 11 cycles.
- in_key and in_ct are sampled only at acceptance. Changes while busy have no effect. in_valid while busy is held off, since in_ready=0.
- out_ready while out_valid=0 is ignored.
- Reset mid-operation (any state): everything returns to reset values immediately. The partial result is discarded and no out_valid pulse occurs.
- Datapath: pure combinational functions of st, rk and rnd. Round-key select is a 128-bit mux on 10-rnd. No arithmetic beyond the 4-bit rnd counter, which never wraps because it is cleared in PRE.

Optional Feature:
Macro AES_DEC_KEY_CACHE_EN.
- Defined: the block adds a registered copy of the expanded key schedule (1408 bits) and a 128-bit last_key register.
  - On acceptance with in_key == last_key and the cache valid, the cached schedule is reused.
  - On acceptance with a new key, PRE is preceded by one extra LOAD cycle that registers the schedule. Latency becomes 12 cycles.
  - Reset invalidates the cache.
- Undefined: the schedule is combinational from key_q, no LOAD state exists, and latency is always 11.

Decomposition:
- Package aes_dec_pkg holds:
  - FSM state enum (IDLE, PRE, ROUND, FINAL, DONE, LOAD)
  - NR=10, BLK_W=128, KS_W=1408
  - function rk_sel(schedule, idx) returning a 128-bit slice
- Sub-module aes_dec_round_core: combinational single inverse round with a mode input (pre / mid / final). It instantiates the existing AddRoundKey, Inv_MixColumns, InvShiftRows and InvSubBytes.
- KeyExpansion is instantiated unchanged.

Test Plan:
- Reset, then a single block: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a. Required: out_pt 00112233445566778899aabbccddeeff, and out_valid exactly 11 cycles after acceptance.
- Key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32. Required: out_pt 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_pt stable, in_ready=0. Then out_ready=1 with in_valid=1. Required: the next block is accepted in the same cycle and its result is correct 11 cycles later.
- in_valid held high with changing in_ct while busy. Required: in_ready=0 and the result matches only the first accepted ct.
- Assert rst_n=0 at round 5. Required: out_valid=0, busy=0, in_ready=1 immediately. A subsequent block decrypts correctly.
- With AES_DEC_KEY_CACHE_EN: two blocks with the same key take 12 then 11 cycles. A third block with a new key takes 12 cycles. All results match FIPS-197.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the iterative AES-128 decryptor.
// Used by aes_dec_iter_ctrl (optional key-schedule cache: AES_DEC_KEY_CACHE_EN).
package aes_dec_pkg;
  localparam int NR    = 10;
  localparam int BLK_W = 128;
  localparam int KS_W  = (NR + 1) * BLK_W;

  typedef enum logic [2:0] {IDLE, PRE, ROUND, FINAL, DONE, LOAD} state_e;
  typedef enum logic [1:0] {MODE_PRE, MODE_MID, MODE_FINAL} rmode_e;

  // Round key r sits at bits [r*128 +: 128] of the schedule.
  function automatic logic [BLK_W-1:0] rk_sel(input logic [KS_W-1:0] sched, input logic [3:0] idx);
    return sched[idx*BLK_W +: BLK_W];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 via a fixed square/multiply chain; maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] x3, x7, x15, x31, x63, x127;
    x3   = gmul(gmul(a, a), a);
    x7   = gmul(gmul(x3, x3), a);
    x15  = gmul(gmul(x7, x7), a);
    x31  = gmul(gmul(x15, x15), a);
    x63  = gmul(gmul(x31, x31), a);
    x127 = gmul(gmul(x63, x63), a);
    return gmul(x127, x127);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction
endpackage

// File: rtl/aes_dec_key_exp.sv
// AES-128 KeyExpansion: cipher key in, all 11 round keys out, purely combinational.
module KeyExpansion import aes_dec_pkg::*; (
  input  logic [BLK_W-1:0] key_i,
  output logic [KS_W-1:0]  ks_o
);
  logic [31:0] w [0:43];
  logic [31:0] t;
  logic [7:0]  rc;

  always_comb begin
    rc = 8'h01;
    t  = '0;
    ks_o = '0;
    for (int i = 0; i < 4; i++) w[i] = key_i[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      ks_o[r*BLK_W +: BLK_W] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end
endmodule

// File: rtl/aes_dec_round_core.sv
// Single inverse AES round with selectable shape (pre / mid / final) and its primitives.
module AddRoundKey import aes_dec_pkg::*; (
  input  logic [BLK_W-1:0] st_i,
  input  logic [BLK_W-1:0] rk_i,
  output logic [BLK_W-1:0] st_o
);
  assign st_o = st_i ^ rk_i;
endmodule

module InvShiftRows import aes_dec_pkg::*; (
  input  logic [BLK_W-1:0] st_i,
  output logic [BLK_W-1:0] st_o
);
  // Byte (row r, col c) lives at index 4*c+r, MSB first.
  for (genvar c = 0; c < 4; c++) begin : g_c
    for (genvar r = 0; r < 4; r++) begin : g_r
      assign st_o[127-8*(4*c+r) -: 8] = st_i[127-8*(4*((c+4-r)%4)+r) -: 8];
    end
  end
endmodule

module InvSubBytes import aes_dec_pkg::*; (
  input  logic [BLK_W-1:0] st_i,
  output logic [BLK_W-1:0] st_o
);
  for (genvar i = 0; i < 16; i++) begin : g_b
    assign st_o[8*i +: 8] = inv_sbox(st_i[8*i +: 8]);
  end
endmodule

module Inv_MixColumns import aes_dec_pkg::*; (
  input  logic [BLK_W-1:0] st_i,
  output logic [BLK_W-1:0] st_o
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [7:0] a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = st_i[127-32*c -: 32];
    assign st_o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
    assign st_o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
    assign st_o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
    assign st_o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
  end
endmodule

module aes_dec_round_core import aes_dec_pkg::*; (
  input  rmode_e           mode_i,
  input  logic [BLK_W-1:0] st_i,
  input  logic [BLK_W-1:0] rk_i,
  output logic [BLK_W-1:0] st_o
);
  logic [BLK_W-1:0] ark, imc, isr_in, isr, isb;

  AddRoundKey    u_ark (.st_i(st_i),   .rk_i(rk_i), .st_o(ark));
  Inv_MixColumns u_imc (.st_i(ark),    .st_o(imc));
  assign isr_in = (mode_i == MODE_MID) ? imc : ark;
  InvShiftRows   u_isr (.st_i(isr_in), .st_o(isr));
  InvSubBytes    u_isb (.st_i(isr),    .st_o(isb));
  assign st_o = (mode_i == MODE_FINAL) ? ark : isb;
endmodule

// File: rtl/aes_dec_iter_ctrl.sv
// Iterative AES-128 decryption sequencer: one shared inverse round, 11 cycles per block.
// Define AES_DEC_KEY_CACHE_EN to register the key schedule and skip re-expansion on key reuse.
module aes_dec_iter_ctrl #(
  parameter int NR    = 10,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BLK_W-1:0] in_ct,
  input  logic [BLK_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] out_pt,
  output logic             busy
);
  import aes_dec_pkg::*;

  if (NR != 10 || BLK_W != 128) begin : g_bad_cfg
    $error("aes_dec_iter_ctrl supports only AES-128 (NR=10, BLK_W=128)");
  end

  state_e           state_q;
  logic [3:0]       rnd_q;
  logic [BLK_W-1:0] st_q, key_q, out_pt_q;
  logic             out_valid_q;
  logic [KS_W-1:0]  ks_comb, sched;
  logic [3:0]       rk_idx;
  rmode_e           mode;
  logic [BLK_W-1:0] rk, rnd_out;
  logic             accept, cache_hit;

  KeyExpansion u_ke (.key_i(key_q), .ks_o(ks_comb));

`ifdef AES_DEC_KEY_CACHE_EN
  logic [KS_W-1:0]  ks_q;
  logic [BLK_W-1:0] last_key_q;
  logic             cache_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks_q        <= '0;
      last_key_q  <= '0;
      cache_vld_q <= 1'b0;
    end else if (state_q == LOAD) begin
      ks_q        <= ks_comb;
      last_key_q  <= key_q;
      cache_vld_q <= 1'b1;
    end
  end

  assign sched     = ks_q;
  assign cache_hit = cache_vld_q & (in_key == last_key_q);
`else
  assign sched     = ks_comb;
  assign cache_hit = 1'b1;
`endif

  always_comb begin
    mode   = MODE_FINAL;
    rk_idx = 4'd0;
    unique case (state_q)
      PRE:     begin mode = MODE_PRE; rk_idx = 4'(NR);         end
      ROUND:   begin mode = MODE_MID; rk_idx = 4'(NR) - rnd_q; end
      default: begin mode = MODE_FINAL; rk_idx = 4'd0;         end
    endcase
  end

  assign rk = rk_sel(sched, rk_idx);

  aes_dec_round_core u_core (.mode_i(mode), .st_i(st_q), .rk_i(rk), .st_o(rnd_out));

  // A finished block can hand over to the next one in the same cycle it is consumed.
  assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state_q == PRE) | (state_q == ROUND) | (state_q == FINAL) | (state_q == LOAD);
  assign out_valid = out_valid_q;
  assign out_pt    = out_pt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      st_q        <= '0;
      key_q       <= '0;
      out_pt_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (state_q == DONE && out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
          if (accept) begin
            st_q    <= in_ct;
            key_q   <= in_key;
            state_q <= cache_hit ? PRE : LOAD;
          end
        end
        LOAD: state_q <= PRE;
        PRE: begin
          st_q    <= rnd_out;
          rnd_q   <= 4'd1;
          state_q <= ROUND;
        end
        ROUND: begin
          st_q  <= rnd_out;
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'(NR - 1)) state_q <= FINAL;
        end
        FINAL: begin
          out_pt_q    <= rnd_out;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_dec_iter_ctrl.sv
// Directed bench for aes_dec_iter_ctrl using FIPS-197 and SP800-38A AES-128 vectors.
module tb_aes_dec_iter_ctrl;
`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] PT1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2 = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] PT2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] CT3 = 128'h43b1cd7f598ece23881b00e3ed030688;
  localparam logic [127:0] PT3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] CT4 = 128'h7b0c785e27e8ad3f8223207104725dd4;
  localparam logic [127:0] PT4 = 128'hf69f2445df4f9b17ad2b417be66c3710;

  logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] in_ct = '0, in_key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_pt;

  int           n_chk = 0, n_fail = 0;
  logic [127:0] last_key = '0;
  bit           cache_v = 1'b0;
  int           lat;

  always #5 clk = ~clk;

  aes_dec_iter_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ct(in_ct), .in_key(in_key), .out_valid(out_valid), .out_ready(out_ready),
    .out_pt(out_pt), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_lat(input logic [127:0] k);
    if (!CACHE) return 11;
    return (cache_v && k == last_key) ? 11 : 12;
  endfunction

  task automatic accept(input string tag, input logic [127:0] k, input logic [127:0] ct, output int exp_l);
    int n = 0;
    in_key = k; in_ct = ct; in_valid = 1'b1;
    while (!in_ready && n < 40) begin step(); n++; end
    chkb({tag, "_in_ready"}, in_ready, 1'b1);
    exp_l = exp_lat(k);
    step();
    in_valid = 1'b0;
    last_key = k; cache_v = 1'b1;
  endtask

  task automatic wait_out(input string tag, input logic [127:0] exp_pt, input int exp_l, input bit noise);
    int n = 0;
    while (!out_valid && n < 40) begin
      step(); n++;
      if (noise) begin
        in_ct  = {$urandom, $urandom, $urandom, $urandom};
        in_key = {$urandom, $urandom, $urandom, $urandom};
        chkb({tag, "_held_off"}, in_ready, 1'b0);
      end
    end
    chki({tag, "_latency"}, n, exp_l);
    chk({tag, "_pt"}, out_pt, exp_pt);
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #1;
    chkb({tag, "_consumed"}, out_valid, 1'b0);
    chkb({tag, "_idle_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    step(); step();
    chkb("rst_in_ready", in_ready, 1'b1);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chk("rst_out_pt", out_pt, '0);
    rst_n = 1'b1;
    step();
    chkb("post_rst_in_ready", in_ready, 1'b1);

    // FIPS-197 C.1
    accept("c1", K0, CT0, lat);
    chkb("c1_busy", busy, 1'b1);
    chkb("c1_not_ready", in_ready, 1'b0);
    wait_out("c1", PT0, lat, 1'b0);
    consume("c1");

    // FIPS-197 Appendix B, then backpressure
    accept("b", KB, CTB, lat);
    wait_out("b", PTB, lat, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_pt_stable", out_pt, PTB);
      chkb("bp_valid_held", out_valid, 1'b1);
      chkb("bp_in_ready", in_ready, 1'b0);
    end

    // Release with a new pair in the same cycle
    in_key = KB; in_ct = CT1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chkb("b2b_in_ready", in_ready, 1'b1);
    lat = exp_lat(KB);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    last_key = KB; cache_v = 1'b1;
    chkb("b2b_valid_drop", out_valid, 1'b0);
    chkb("b2b_busy", busy, 1'b1);
    wait_out("b2b", PT1, lat, 1'b0);
    consume("b2b");

    // in_valid held with changing inputs while busy
    accept("hold", KB, CT2, lat);
    in_valid = 1'b1;
    wait_out("hold", PT2, lat, 1'b1);
    chkb("hold_done_not_ready", in_ready, 1'b0);
    in_valid = 1'b0;
    consume("hold");

    // Reset in the middle of round 5
    accept("mid", K0, CT0, lat);
    for (int i = 0; i < 5 + (lat - 11); i++) step();
    chkb("mid_busy_before", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    cache_v = 1'b0;
    chkb("mid_rst_out_valid", out_valid, 1'b0);
    chkb("mid_rst_busy", busy, 1'b0);
    chkb("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_out_pt", out_pt, '0);
    step();
    rst_n = 1'b1;
    step();
    chkb("mid_no_pulse", out_valid, 1'b0);

    // Recovery block, then same-key block
    accept("rec", KB, CT3, lat);
    wait_out("rec", PT3, lat, 1'b0);
    consume("rec");
    accept("same", KB, CT4, lat);
    wait_out("same", PT4, lat, 1'b0);
    consume("same");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
